nonce_scheduler: RTL and testbench

NONCE_SCHEDULER -- requirements
Module: nonce_scheduler

---
 rtl/nonce_scheduler.sv | 155 +++++++++++++++
 tb/tb_nonce_scheduler.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/nonce_scheduler.sv
// Nonce scheduler: streams one nonce per cycle into a fixed-latency hasher and
// matches results against a tag delay line, buffering at most one hit.
module nonce_scheduler #(
  parameter int HASH_DELAY = 72,
  parameter int NONCE_WORD = 3
) (
  input  logic               Clk,
  input  logic               Rst_I,
  input  logic               Job_Vld_I,
  output logic               Job_Rdy_O,
  input  logic [7:0][31:0]   Job_H_I,
  input  logic [15:0][31:0]  Job_Msg_I,
  input  logic [31:0]        Job_Nonce_I,
  input  logic [31:0]        Job_Cnt_I,
  input  logic [31:0]        Job_Target_I,
  input  logic               Abort_I,
  output logic               Hg_Vld_O,
  output logic [7:0][31:0]   Hg_H_O,
  output logic [15:0][31:0]  Hg_Msg_O,
  input  logic [7:0][31:0]   Hg_H_I,
  output logic               Found_Vld_O,
  output logic [31:0]        Found_Nonce_O,
  input  logic               Found_Rdy_I,
  output logic               Busy_O,
  output logic               Ovf_O
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [7:0][31:0]    r_h;
  logic [15:0][31:0]   r_msg;
  logic [31:0]         r_target;
  logic [31:0]         r_cur;
  logic [31:0]         r_rem;
  logic                r_dl_vld   [HASH_DELAY];
  logic [31:0]         r_dl_nonce [HASH_DELAY];
  logic                r_found_vld;
  logic [31:0]         r_found_nonce;
  logic                r_ovf;

  logic                w_accept;
  logic                w_abort;
  logic                w_issue;
  logic                w_pending;
  logic                w_hit;
  logic                w_pop;
  logic                w_unused_hash;

  assign w_accept = (r_state == S_IDLE) && Job_Vld_I;
  assign w_abort  = Abort_I && (r_state != S_IDLE);
  assign w_issue  = (r_state == S_RUN) && !Abort_I;
  assign w_pop    = r_found_vld && Found_Rdy_I;
  assign w_hit    = r_dl_vld[HASH_DELAY-1] && (Hg_H_I[0] < r_target) && !w_abort;
  assign w_unused_hash = ^Hg_H_I[7:1];

  // Tags that will still be in flight after this edge (the output stage retires now).
  always_comb begin
    w_pending = 1'b0;
    for (int i = 0; i < HASH_DELAY - 1; i++) begin
      w_pending = w_pending | r_dl_vld[i];
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (Job_Vld_I) w_state_next = (Job_Cnt_I == 32'd0) ? S_DRAIN : S_RUN;
      end
      S_RUN: begin
        if (Abort_I)            w_state_next = S_IDLE;
        else if (r_rem == 32'd1) w_state_next = S_DRAIN;
      end
      S_DRAIN: begin
        if (Abort_I || !w_pending) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst_I) begin
      r_state  <= S_IDLE;
      r_h      <= '0;
      r_msg    <= '0;
      r_target <= '0;
      r_cur    <= '0;
      r_rem    <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_h      <= Job_H_I;
        r_msg    <= Job_Msg_I;
        r_target <= Job_Target_I;
        r_cur    <= Job_Nonce_I;
        r_rem    <= Job_Cnt_I;
      end else if (w_issue) begin
        r_cur <= r_cur + 32'd1;
        r_rem <= r_rem - 32'd1;
      end
    end
  end

  // Tag line shifts unconditionally; abort only kills the valid bits.
  always_ff @(posedge Clk) begin
    if (Rst_I) begin
      for (int i = 0; i < HASH_DELAY; i++) begin
        r_dl_vld[i]   <= 1'b0;
        r_dl_nonce[i] <= '0;
      end
    end else begin
      r_dl_vld[0]   <= w_issue && !w_abort;
      r_dl_nonce[0] <= r_cur;
      for (int i = 1; i < HASH_DELAY; i++) begin
        r_dl_vld[i]   <= w_abort ? 1'b0 : r_dl_vld[i-1];
        r_dl_nonce[i] <= r_dl_nonce[i-1];
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst_I) begin
      r_found_vld   <= 1'b0;
      r_found_nonce <= '0;
      r_ovf         <= 1'b0;
    end else begin
      if (w_hit) begin
        if (!r_found_vld || w_pop) begin
          r_found_vld   <= 1'b1;
          r_found_nonce <= r_dl_nonce[HASH_DELAY-1];
        end else begin
          r_ovf <= 1'b1;
        end
      end else if (w_pop) begin
        r_found_vld <= 1'b0;
      end
    end
  end

  always_comb begin
    Hg_Msg_O             = r_msg;
    Hg_Msg_O[NONCE_WORD] = r_cur;
  end

  assign Job_Rdy_O     = (r_state == S_IDLE);
  assign Busy_O        = (r_state != S_IDLE);
  assign Hg_Vld_O      = w_issue;
  assign Hg_H_O        = r_h;
  assign Found_Vld_O   = r_found_vld;
  assign Found_Nonce_O = r_found_nonce;
  assign Ovf_O         = r_ovf;

endmodule

// File: tb/tb_nonce_scheduler.sv
// Directed bench for nonce_scheduler with a behavioural fixed-latency hasher
// whose word 0 is (issued nonce ^ key).
module tb_nonce_scheduler;
  localparam int HD = 6;
  localparam int NW = 3;

  logic              clk = 1'b0;
  logic              Rst_I;
  logic              Job_Vld_I;
  logic              Job_Rdy_O;
  logic [7:0][31:0]  Job_H_I;
  logic [15:0][31:0] Job_Msg_I;
  logic [31:0]       Job_Nonce_I, Job_Cnt_I, Job_Target_I;
  logic              Abort_I;
  logic              Hg_Vld_O;
  logic [7:0][31:0]  Hg_H_O;
  logic [15:0][31:0] Hg_Msg_O;
  logic [7:0][31:0]  Hg_H_I;
  logic              Found_Vld_O;
  logic [31:0]       Found_Nonce_O;
  logic              Found_Rdy_I;
  logic              Busy_O, Ovf_O;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] key = 32'h0;

  always #5 clk = ~clk;

  nonce_scheduler #(.HASH_DELAY(HD), .NONCE_WORD(NW)) dut (
    .Clk(clk), .Rst_I(Rst_I),
    .Job_Vld_I(Job_Vld_I), .Job_Rdy_O(Job_Rdy_O),
    .Job_H_I(Job_H_I), .Job_Msg_I(Job_Msg_I),
    .Job_Nonce_I(Job_Nonce_I), .Job_Cnt_I(Job_Cnt_I), .Job_Target_I(Job_Target_I),
    .Abort_I(Abort_I),
    .Hg_Vld_O(Hg_Vld_O), .Hg_H_O(Hg_H_O), .Hg_Msg_O(Hg_Msg_O), .Hg_H_I(Hg_H_I),
    .Found_Vld_O(Found_Vld_O), .Found_Nonce_O(Found_Nonce_O), .Found_Rdy_I(Found_Rdy_I),
    .Busy_O(Busy_O), .Ovf_O(Ovf_O)
  );

  // Hasher model: result for an issue in cycle t is presented during cycle t+HD.
  logic [HD-1:0] m_vld = '0;
  logic [31:0]   m_nonce [HD];
  always @(posedge clk) begin
    m_vld      <= {m_vld[HD-2:0], Hg_Vld_O};
    m_nonce[0] <= Hg_Msg_O[NW];
    for (int i = 1; i < HD; i++) m_nonce[i] <= m_nonce[i-1];
  end
  always_comb begin
    for (int i = 0; i < 8; i++) Hg_H_I[i] = 32'hC000_0000 + i;
    Hg_H_I[0] = m_vld[HD-1] ? (m_nonce[HD-1] ^ key) : 32'hFFFF_FFFF;
  end

  function automatic logic [511:0] exp_msg(input logic [31:0] nonce);
    logic [15:0][31:0] m;
    for (int i = 0; i < 16; i++) m[i] = 32'hA000_0000 + i;
    m[NW] = nonce;
    return m;
  endfunction

  function automatic logic [255:0] exp_h();
    logic [7:0][31:0] h;
    for (int i = 0; i < 8; i++) h[i] = 32'h1000_0000 + i;
    return h;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check_wide(input string tag, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input logic [31:0] nonce, input logic [31:0] cnt, input logic [31:0] target);
    Job_Nonce_I  = nonce;
    Job_Cnt_I    = cnt;
    Job_Target_I = target;
    Job_Vld_I    = 1'b1;
    check("job_rdy_before_accept", {31'd0, Job_Rdy_O}, 32'd1);
    tick();
    Job_Vld_I = 1'b0;
    $display("job accepted nonce=%h cnt=%0d target=%h", nonce, cnt, target);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n;
    n = 0;
    while (Busy_O && n < budget) begin
      tick();
      n++;
    end
    check(tag, {31'd0, Busy_O}, 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_job_rdy"}, {31'd0, Job_Rdy_O}, 32'd1);
    check({tag, "_hg_vld"}, {31'd0, Hg_Vld_O}, 32'd0);
    check({tag, "_found_vld"}, {31'd0, Found_Vld_O}, 32'd0);
    check({tag, "_found_nonce"}, Found_Nonce_O, 32'd0);
    check({tag, "_busy"}, {31'd0, Busy_O}, 32'd0);
    check({tag, "_ovf"}, {31'd0, Ovf_O}, 32'd0);
    check_wide({tag, "_hg_h"}, {256'd0, Hg_H_O}, 512'd0);
    check_wide({tag, "_hg_msg"}, Hg_Msg_O, 512'd0);
  endtask

  initial begin
    Rst_I = 1'b1; Job_Vld_I = 1'b0; Abort_I = 1'b0; Found_Rdy_I = 1'b0;
    Job_Nonce_I = '0; Job_Cnt_I = '0; Job_Target_I = '0;
    for (int i = 0; i < 8; i++)  Job_H_I[i]   = 32'h1000_0000 + i;
    for (int i = 0; i < 16; i++) Job_Msg_I[i] = 32'hA000_0000 + i;
    tick(); tick();
    Rst_I = 1'b0;
    check_reset_outputs("reset");

    // Basic job: only nonce 0x13 hashes below target 1.
    key = 32'h13;
    start_job(32'h10, 32'd4, 32'd1);
    for (int k = 0; k < 4; k++) begin
      check("basic_hg_vld", {31'd0, Hg_Vld_O}, 32'd1);
      check("basic_nonce", Hg_Msg_O[NW], 32'h10 + k);
      check("basic_job_rdy", {31'd0, Job_Rdy_O}, 32'd0);
      if (k == 0) begin
        check_wide("basic_msg", Hg_Msg_O, exp_msg(32'h10));
        check_wide("basic_h", {256'd0, Hg_H_O}, {256'd0, exp_h()});
      end
      $display("issue nonce=%h", Hg_Msg_O[NW]);
      tick();
    end
    for (int d = 1; d <= HD; d++) begin
      check("drain_hg_vld", {31'd0, Hg_Vld_O}, 32'd0);
      check("drain_found_early", {31'd0, Found_Vld_O}, 32'd0);
      check("drain_busy", {31'd0, Busy_O}, 32'd1);
      tick();
    end
    check("basic_found_vld", {31'd0, Found_Vld_O}, 32'd1);
    check("basic_found_nonce", Found_Nonce_O, 32'h13);
    check("basic_busy_fall", {31'd0, Busy_O}, 32'd0);
    check("basic_job_rdy_back", {31'd0, Job_Rdy_O}, 32'd1);
    Found_Rdy_I = 1'b1; tick(); Found_Rdy_I = 1'b0;
    check("basic_pop", {31'd0, Found_Vld_O}, 32'd0);

    // Nonce wraps through zero.
    key = 32'h0;
    start_job(32'hFFFF_FFFE, 32'd3, 32'd0);
    check("wrap_n0", Hg_Msg_O[NW], 32'hFFFF_FFFE); tick();
    check("wrap_n1", Hg_Msg_O[NW], 32'hFFFF_FFFF); tick();
    check("wrap_n2", Hg_Msg_O[NW], 32'h0000_0000); tick();
    check("wrap_stop", {31'd0, Hg_Vld_O}, 32'd0);
    wait_idle("wrap_idle", 3 * HD);
    check("wrap_no_hit", {31'd0, Found_Vld_O}, 32'd0);

    // Empty job.
    start_job(32'h5, 32'd0, 32'd0);
    check("empty_hg_vld", {31'd0, Hg_Vld_O}, 32'd0);
    check("empty_busy", {31'd0, Busy_O}, 32'd1);
    tick();
    check("empty_idle", {31'd0, Busy_O}, 32'd0);
    check("empty_job_rdy", {31'd0, Job_Rdy_O}, 32'd1);

    // Three hits back to back with nobody popping.
    key = 32'h20;
    start_job(32'h20, 32'd3, 32'd4);
    repeat (HD + 1) tick();
    check("ovf_first_hit", {31'd0, Found_Vld_O}, 32'd1);
    check("ovf_first_nonce", Found_Nonce_O, 32'h20);
    check("ovf_not_yet", {31'd0, Ovf_O}, 32'd0);
    tick();
    check("ovf_set", {31'd0, Ovf_O}, 32'd1);
    check("ovf_nonce_held", Found_Nonce_O, 32'h20);
    wait_idle("ovf_idle", 3 * HD);
    check("ovf_nonce_final", Found_Nonce_O, 32'h20);

    // Hit arriving in the same cycle as a pop replaces the entry.
    key = 32'h40;
    start_job(32'h40, 32'd1, 32'd1);
    check("pop_issue", Hg_Msg_O[NW], 32'h40);
    repeat (HD) tick();
    Found_Rdy_I = 1'b1;
    check("pop_old_vld", {31'd0, Found_Vld_O}, 32'd1);
    tick();
    Found_Rdy_I = 1'b0;
    check("pop_new_vld", {31'd0, Found_Vld_O}, 32'd1);
    check("pop_new_nonce", Found_Nonce_O, 32'h40);
    check("pop_ovf_sticky", {31'd0, Ovf_O}, 32'd1);
    Found_Rdy_I = 1'b1; tick(); Found_Rdy_I = 1'b0;
    check("pop_empty", {31'd0, Found_Vld_O}, 32'd0);

    // Abort two cycles into RUN drops in-flight hits.
    key = 32'h50;
    start_job(32'h50, 32'd10, 32'h10);
    check("abort_run_vld", {31'd0, Hg_Vld_O}, 32'd1);
    tick(); tick();
    Abort_I = 1'b1;
    tick();
    Abort_I = 1'b0;
    check("abort_hg_vld", {31'd0, Hg_Vld_O}, 32'd0);
    check("abort_busy", {31'd0, Busy_O}, 32'd0);
    check("abort_job_rdy", {31'd0, Job_Rdy_O}, 32'd1);
    for (int d = 0; d < 2 * HD; d++) begin
      check("abort_no_found", {31'd0, Found_Vld_O}, 32'd0);
      tick();
    end

    // Abort in DRAIN coinciding with the hit at the line output.
    key = 32'h60;
    start_job(32'h60, 32'd1, 32'd1);
    repeat (HD) tick();
    Abort_I = 1'b1;
    tick();
    Abort_I = 1'b0;
    check("abort_hit_found", {31'd0, Found_Vld_O}, 32'd0);
    check("abort_hit_busy", {31'd0, Busy_O}, 32'd0);

    // Abort while idle has no effect.
    Abort_I = 1'b1;
    tick();
    Abort_I = 1'b0;
    check("idle_abort_rdy", {31'd0, Job_Rdy_O}, 32'd1);
    check("idle_abort_ovf", {31'd0, Ovf_O}, 32'd1);

    // Reset mid-RUN, then a new job straight away.
    key = 32'h0;
    start_job(32'h70, 32'd20, 32'd0);
    tick(); tick();
    check("pre_rst_busy", {31'd0, Busy_O}, 32'd1);
    Rst_I = 1'b1;
    tick();
    Rst_I = 1'b0;
    check_reset_outputs("midrun_rst");
    start_job(32'h80, 32'd2, 32'd0);
    check("post_rst_vld", {31'd0, Hg_Vld_O}, 32'd1);
    check_wide("post_rst_msg", Hg_Msg_O, exp_msg(32'h80));
    wait_idle("post_rst_idle", 3 * HD);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
